// File: rtl/microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : microsequencer
// Description : Control sequencer for the bus-based CPU. Keeps the T-state
//               counter and forms the microcode ROM address from the opcode
//               and the T-state. Decodes the sequencing fields of the
//               returned micro-word and holds the {GT, C, Z} flag register.
//               Generates the conditional-jump strobe and drives the IR
//               immediate onto the bus.
//
// Ports       : clk         - system clock, rising edge
//               reset_bar   - asynchronous active-low reset
//               stall       - hold T-state and suppress every strobe
//               ir_val      - instruction register contents
//               alu_result  - ALU output used for flag capture
//               alu_carry   - ALU carry-out
//               uword       - micro-word read from the ROM at uaddr
//               uaddr       - ROM address {opcode_eff, tstate}
//               ctrl_out    - pass-through control bits uword[UW-1:10], gated
//               jmp         - PC load strobe
//               ir_bus      - IR immediate value for the bus
//               ir_oe       - ir_bus drive enable
//               flags       - {GT, C, Z}
//               tstate      - current T-state
//               halted      - sequencer halted
//               instr_count - completed-instruction counter
//
// Revision    : 1.0 - initial release
// ============================================================================
module microsequencer #(
    parameter int WIDTH       = 16,
    parameter int OPCODE_BITS = 8,
    parameter int TSTATE_BITS = 3,
    parameter int IMM_BITS    = 8,
    parameter int FETCH_T     = 2,
    parameter int UW          = 24
) (
    input  logic                           clk,
    input  logic                           reset_bar,
    input  logic                           stall,
    input  logic [WIDTH-1:0]               ir_val,
    input  logic [WIDTH-1:0]               alu_result,
    input  logic                           alu_carry,
    input  logic [UW-1:0]                  uword,
    output logic [OPCODE_BITS+TSTATE_BITS-1:0] uaddr,
    output logic [UW-11:0]                 ctrl_out,
    output logic                           jmp,
    output logic [WIDTH-1:0]               ir_bus,
    output logic                           ir_oe,
    output logic [2:0]                     flags,
    output logic [TSTATE_BITS-1:0]         tstate,
    output logic                           halted,
    output logic [WIDTH-1:0]               instr_count
);

    localparam logic [0:0]             c_st_run  = 1'b0;
    localparam logic [0:0]             c_st_halt = 1'b1;
    localparam logic [TSTATE_BITS-1:0] c_fetch_t = TSTATE_BITS'(FETCH_T);

    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic [TSTATE_BITS-1:0] r_tstate;
    logic [WIDTH-1:0]       r_instr_count;
    logic [2:0]             r_flags;       // {GT, C, Z}

    logic                   w_active;
    logic                   w_jz, w_jnz, w_jgt, w_jlt, w_jc;
    logic                   w_iol, w_ioh, w_fl, w_rt, w_hlt;
    logic                   w_end;
    logic                   w_z_new;
    logic [OPCODE_BITS-1:0] w_opcode_eff;
    logic [IMM_BITS-1:0]    w_imm;

    // Micro-word sequencing fields
    assign w_jz  = uword[0];
    assign w_jnz = uword[1];
    assign w_jgt = uword[2];
    assign w_jlt = uword[3];
    assign w_jc  = uword[4];
    assign w_iol = uword[5];
    assign w_ioh = uword[6];
    assign w_fl  = uword[7];
    assign w_rt  = uword[8];
    assign w_hlt = uword[9];

    assign w_active = (r_state == c_st_run) && !stall;

    // Fetch T-states share the opcode-0 microcode.
    assign w_opcode_eff = (r_tstate < c_fetch_t) ? '0 : ir_val[WIDTH-1 -: OPCODE_BITS];
    assign uaddr        = {w_opcode_eff, r_tstate};

    // Instruction ends on RT, HLT, or the last T-state.
    assign w_end   = w_rt || w_hlt || (r_tstate == '1);
    assign w_z_new = (alu_result == '0);
    assign w_imm   = ir_val[IMM_BITS-1:0];

    // ------------------------------------------------------------------------
    // FSM: RUN until an unstalled HLT; HALT is left only through reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run:  if (w_active && w_hlt) w_state_nxt = c_st_halt;
            c_st_halt: w_state_nxt = c_st_halt;
            default:   w_state_nxt = c_st_run;
        endcase
    end

    // ------------------------------------------------------------------------
    // T-state, instruction counter and flag register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            r_tstate      <= '0;
            r_instr_count <= '0;
            r_flags       <= '0;
        end else if (w_active) begin
            if (w_end) begin
                r_tstate      <= '0;
                r_instr_count <= r_instr_count + 1'b1;
            end else begin
                r_tstate      <= r_tstate + 1'b1;
            end
            if (w_fl) begin
                // GT is signed "greater than zero": sign clear and non-zero.
                r_flags <= {!alu_result[WIDTH-1] && !w_z_new, alu_carry, w_z_new};
            end
        end
    end

    // ------------------------------------------------------------------------
    // Gated strobes; jmp reads the registered (old) flags.
    // ------------------------------------------------------------------------
    always_comb begin
        ctrl_out = '0;
        jmp      = 1'b0;
        ir_oe    = 1'b0;
        ir_bus   = '0;
        if (w_active) begin
            ctrl_out = uword[UW-1:10];
            jmp      = (w_jc  && r_flags[1]) ||
                       (w_jz  && r_flags[0]) ||
                       (w_jnz && !r_flags[0]) ||
                       (w_jgt && r_flags[2]) ||
                       (w_jlt && !r_flags[0] && !r_flags[2]);
            ir_oe    = w_iol || w_ioh;
            if (w_ioh) begin
                ir_bus = {{(WIDTH-IMM_BITS){1'b1}}, w_imm};
            end else if (w_iol) begin
                ir_bus = {{(WIDTH-IMM_BITS){1'b0}}, w_imm};
            end
        end
    end

    assign flags       = r_flags;
    assign tstate      = r_tstate;
    assign halted      = (r_state == c_st_halt);
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_microsequencer
// Description : Directed self-checking bench for microsequencer. A second,
//               narrow instance (WIDTH=4) exercises instruction-counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_microsequencer;

    localparam logic [23:0] c_jz  = 24'h000001;
    localparam logic [23:0] c_jnz = 24'h000002;
    localparam logic [23:0] c_jlt = 24'h000008;
    localparam logic [23:0] c_iol = 24'h000020;
    localparam logic [23:0] c_ioh = 24'h000040;
    localparam logic [23:0] c_fl  = 24'h000080;
    localparam logic [23:0] c_rt  = 24'h000100;
    localparam logic [23:0] c_hlt = 24'h000200;

    logic        clk;
    logic        reset_bar;
    logic        stall;
    logic [15:0] ir_val;
    logic [15:0] alu_result;
    logic        alu_carry;
    logic [23:0] uword;
    logic [10:0] uaddr;
    logic [13:0] ctrl_out;
    logic        jmp;
    logic [15:0] ir_bus;
    logic        ir_oe;
    logic [2:0]  flags;
    logic [2:0]  tstate;
    logic        halted;
    logic [15:0] instr_count;

    // Narrow instance for counter wrap
    logic [3:0]  ir_val2, alu_result2;
    logic [23:0] uword2;
    logic [4:0]  uaddr2;
    logic [13:0] ctrl_out2;
    logic        jmp2, ir_oe2, halted2;
    logic [3:0]  ir_bus2, instr_count2;
    logic [2:0]  flags2, tstate2;

    int n_checks;
    int n_errors;

    microsequencer #(
        .WIDTH(16), .OPCODE_BITS(8), .TSTATE_BITS(3),
        .IMM_BITS(8), .FETCH_T(2), .UW(24)
    ) dut (
        .clk(clk), .reset_bar(reset_bar), .stall(stall), .ir_val(ir_val),
        .alu_result(alu_result), .alu_carry(alu_carry), .uword(uword),
        .uaddr(uaddr), .ctrl_out(ctrl_out), .jmp(jmp), .ir_bus(ir_bus),
        .ir_oe(ir_oe), .flags(flags), .tstate(tstate), .halted(halted),
        .instr_count(instr_count)
    );

    microsequencer #(
        .WIDTH(4), .OPCODE_BITS(2), .TSTATE_BITS(3),
        .IMM_BITS(2), .FETCH_T(2), .UW(24)
    ) dut_narrow (
        .clk(clk), .reset_bar(reset_bar), .stall(1'b0), .ir_val(ir_val2),
        .alu_result(alu_result2), .alu_carry(1'b0), .uword(uword2),
        .uaddr(uaddr2), .ctrl_out(ctrl_out2), .jmp(jmp2), .ir_bus(ir_bus2),
        .ir_oe(ir_oe2), .flags(flags2), .tstate(tstate2), .halted(halted2),
        .instr_count(instr_count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset_bar   = 1'b0;
        stall       = 1'b0;
        ir_val      = 16'h1234;
        alu_result  = 16'h0000;
        alu_carry   = 1'b0;
        uword       = 24'h0;
        ir_val2     = 4'h0;
        alu_result2 = 4'h0;
        uword2      = 24'h0;

        // ---- Reset state ----
        #2;
        check("rst_tstate", 32'(tstate), 32'd0);
        check("rst_flags",  32'(flags), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count",  32'(instr_count), 32'd0);
        check("rst_uaddr",  32'(uaddr), 32'd0);
        #10 reset_bar = 1'b1;   // released at t=12, between edges

        // ---- Free run: fetch T-states use opcode 0 ----
        for (int i = 0; i < 8; i++) begin
            check("run_tstate", 32'(tstate), 32'(i));
            check("run_uaddr",  32'(uaddr),
                  (i < 2) ? 32'(i) : ((32'h12 << 3) | 32'(i)));
            step();
        end
        check("run_wrap_tstate", 32'(tstate), 32'd0);
        check("run_count",       32'(instr_count), 32'd1);

        // ---- RT at T3 ----
        step(); step(); step();
        check("rt_pre_tstate", 32'(tstate), 32'd3);
        uword = c_rt;
        step();
        check("rt_tstate", 32'(tstate), 32'd0);
        check("rt_count",  32'(instr_count), 32'd2);

        // ---- Stall at T2 ----
        uword = 24'h0;
        step(); step();
        stall = 1'b1;
        uword = {14'h3FFF, 10'h0} | c_jnz | c_iol;
        #1;
        check("stall_ctrl", 32'(ctrl_out), 32'd0);
        check("stall_jmp",  32'(jmp), 32'd0);
        check("stall_oe",   32'(ir_oe), 32'd0);
        step(); step();
        check("stall_tstate", 32'(tstate), 32'd2);
        stall = 1'b0;
        #1;
        check("unstall_ctrl", 32'(ctrl_out), 32'h3FFF);
        check("unstall_jnz",  32'(jmp), 32'd1);

        // ---- Flag capture ----
        uword = c_fl; alu_result = 16'h0000; alu_carry = 1'b0;
        step();
        check("flags_zero", 32'(flags), 32'b001);
        alu_result = 16'h0005; alu_carry = 1'b1;
        step();
        check("flags_pos", 32'(flags), 32'b110);
        alu_result = 16'h8000; alu_carry = 1'b0;
        step();
        check("flags_neg", 32'(flags), 32'b000);
        uword = c_jlt; #1;
        check("jlt_neg", 32'(jmp), 32'd1);
        uword = c_jz; #1;
        check("jz_neg", 32'(jmp), 32'd0);
        // Jump and flag latch together: jump sees the old flags
        uword = c_jz | c_fl; alu_result = 16'h0000; #1;
        check("jz_fl_old", 32'(jmp), 32'd0);
        step();
        uword = c_jz; #1;
        check("jz_fl_new", 32'(jmp), 32'd1);

        // ---- IR immediate ----
        ir_val = 16'h12AB;
        uword = c_iol; #1;
        check("iol_bus", 32'(ir_bus), 32'h00AB);
        check("iol_oe",  32'(ir_oe), 32'd1);
        uword = c_ioh; #1;
        check("ioh_bus", 32'(ir_bus), 32'hFFAB);
        uword = c_iol | c_ioh; #1;
        check("both_bus", 32'(ir_bus), 32'hFFAB);
        uword = 24'h0; #1;
        check("none_bus", 32'(ir_bus), 32'h0);
        check("none_oe",  32'(ir_oe), 32'd0);

        // ---- HLT at T4 ----
        reset_bar = 1'b0; #1; reset_bar = 1'b1;
        step(); step(); step(); step();
        check("hlt_pre_tstate", 32'(tstate), 32'd4);
        uword = c_hlt | c_rt;
        step();
        check("hlt_halted", 32'(halted), 32'd1);
        check("hlt_tstate", 32'(tstate), 32'd0);
        check("hlt_count",  32'(instr_count), 32'd1);
        uword = 24'hFFFFFF; alu_result = 16'h0000; alu_carry = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("halt_quiet", {ctrl_out, jmp, ir_oe, tstate, halted}, 32'd1);
            step();
        end
        check("halt_flags", 32'(flags), 32'd0);
        check("halt_count", 32'(instr_count), 32'd1);

        // Asynchronous reset mid-cycle releases HALT at once
        uword = 24'h0;
        #2 reset_bar = 1'b0;
        uword2 = c_rt;
        #1;
        check("areset_halted", 32'(halted), 32'd0);
        check("areset_count",  32'(instr_count), 32'd0);
        #1 reset_bar = 1'b1;
        step();
        check("resume_tstate", 32'(tstate), 32'd1);
        check("resume_halted", 32'(halted), 32'd0);

        // ---- Counter wrap on the narrow instance (one instruction per edge) ----
        for (int i = 0; i < 14; i++) step();
        check("wrap_pre", 32'(instr_count2), 32'd15);
        step();
        check("wrap_zero", 32'(instr_count2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
